// File: rtl/set_access_ctrl.sv
// Sequencing controller for one 8-way set array: accepts CPU loads/stores,
// drives set-array strobes, services misses with a fill + replay, keeps hit/miss stats.
module set_access_ctrl #(
    parameter int ADDR_W     = 36,
    parameter int TIMEOUT    = 64,
    parameter int MAX_REPLAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        set_enable,
    output logic [1:0]        set_write_enable,
    output logic [1:0]        set_force_write,
    output logic [5:0]        set_block_offset,
    output logic [5:0]        set_idx,
    output logic [ADDR_W-13:0] set_tag,
    output logic [63:0]       set_write_data,
    output logic [1:0]        set_data_size,
    output logic [31:0]       set_n_ops,
    input  logic [127:0]      set_out_data,
    input  logic [1:0]        set_read_miss,
    input  logic [1:0]        set_write_miss,
    input  logic [1:0]        set_data_ready,
    input  logic [1:0]        set_op_done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_SET, S_MEM_REQ, S_MEM_WAIT, S_FILL, S_FILL_WAIT, S_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic               write_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [1:0]         size_reg;
    logic [63:0]        wdata_reg, fill_reg, rdata_reg;
    logic               err_reg;
    logic [TMO_W-1:0]   tmo_reg;
    logic [7:0]         replay_reg;
    logic [31:0]        n_ops_reg, hit_reg, miss_reg;
    logic [63:0]        rd_masked;

    logic any_miss, data_rdy, op_done, tmo_last, replay_ok, accept, misaligned;
    logic unused_hi;

    assign any_miss  = (|set_read_miss) || (|set_write_miss);
    assign data_rdy  = |set_data_ready;
    assign op_done   = |set_op_done;
    assign tmo_last  = (tmo_reg == TMO_W'(TIMEOUT - 1));
    assign replay_ok = (replay_reg < 8'(MAX_REPLAY));
    assign accept    = (state_reg == S_IDLE) && req_valid;
    assign unused_hi = ^set_out_data[127:64];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Keep only the low 2^size bytes of the returned word.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign rd_masked[gi*8 +: 8] = (4'(gi) < (4'd1 << size_reg)) ? set_out_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (req_valid) state_next = misaligned ? S_RESP : S_ISSUE;
            S_ISSUE:     state_next = S_WAIT_SET;
            S_WAIT_SET: begin
                if (any_miss)                   state_next = replay_ok ? S_MEM_REQ : S_RESP;
                else if (!write_reg && data_rdy) state_next = S_RESP;
                else if (write_reg && op_done)   state_next = S_RESP;
                else if (tmo_last)               state_next = S_RESP;
            end
            S_MEM_REQ:   if (mem_req_ready) state_next = S_MEM_WAIT;
            S_MEM_WAIT:  if (mem_resp_valid) state_next = S_FILL;
            S_FILL:      state_next = S_FILL_WAIT;
            S_FILL_WAIT: if (op_done || tmo_last) state_next = S_ISSUE;
            S_RESP:      if (resp_ready) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg  <= 1'b0;
            addr_reg   <= '0;
            size_reg   <= 2'd0;
            wdata_reg  <= 64'h0;
            fill_reg   <= 64'h0;
            rdata_reg  <= 64'h0;
            err_reg    <= 1'b0;
            tmo_reg    <= '0;
            replay_reg <= 8'd0;
            n_ops_reg  <= 32'd0;
            hit_reg    <= 32'd0;
            miss_reg   <= 32'd0;
        end else begin
            if (state_reg == S_ISSUE || state_reg == S_FILL)
                tmo_reg <= '0;
            else if (state_reg == S_WAIT_SET || state_reg == S_FILL_WAIT)
                tmo_reg <= tmo_reg + 1'b1;

            if (accept) begin
                write_reg  <= req_write;
                addr_reg   <= req_addr;
                size_reg   <= req_size;
                wdata_reg  <= req_wdata;
                n_ops_reg  <= n_ops_reg + 32'd1;
                err_reg    <= misaligned;
                rdata_reg  <= 64'h0;
                replay_reg <= 8'd0;
            end

            if (state_reg == S_WAIT_SET) begin
                if (any_miss) begin
                    // Replays that miss again are not counted a second time.
                    if (replay_reg == 8'd0 && miss_reg != 32'hFFFF_FFFF) miss_reg <= miss_reg + 32'd1;
                    if (!replay_ok) err_reg <= 1'b1;
                end else if (!write_reg && data_rdy) begin
                    rdata_reg <= rd_masked;
                    if (hit_reg != 32'hFFFF_FFFF) hit_reg <= hit_reg + 32'd1;
                end else if (write_reg && op_done) begin
                    if (hit_reg != 32'hFFFF_FFFF) hit_reg <= hit_reg + 32'd1;
                end else if (tmo_last) begin
                    err_reg <= 1'b1;
                end
            end

            if (state_reg == S_MEM_WAIT && mem_resp_valid) fill_reg <= mem_resp_data;
            if (state_reg == S_FILL_WAIT && (op_done || tmo_last)) replay_reg <= replay_reg + 8'd1;
        end
    end

    always_comb begin
        logic fill_phase;
        fill_phase       = (state_reg == S_FILL) || (state_reg == S_FILL_WAIT);
        req_ready        = (state_reg == S_IDLE);
        resp_valid       = (state_reg == S_RESP);
        resp_rdata       = rdata_reg;
        resp_err         = err_reg;
        set_enable       = (state_reg == S_ISSUE || state_reg == S_FILL) ? 2'd1 : 2'd0;
        set_write_enable = 2'd0;
        set_force_write  = 2'd0;
        if (state_reg == S_ISSUE || state_reg == S_WAIT_SET)
            set_write_enable = {1'b0, write_reg};
        if (fill_phase) begin
            set_write_enable = 2'd2;
            set_force_write  = 2'd1;
        end
        set_block_offset = fill_phase ? {addr_reg[5:3], 3'b000} : addr_reg[5:0];
        set_idx          = addr_reg[11:6];
        set_tag          = addr_reg[ADDR_W-1:12];
        set_write_data   = fill_phase ? fill_reg : wdata_reg;
        set_data_size    = fill_phase ? 2'd3 : size_reg;
        set_n_ops        = n_ops_reg;
        mem_req_valid    = (state_reg == S_MEM_REQ);
        mem_req_addr     = (state_reg == S_MEM_REQ) ? {addr_reg[ADDR_W-1:3], 3'b000} : '0;
        hit_count        = hit_reg;
        miss_count       = miss_reg;
    end
endmodule

// File: tb/tb_set_access_ctrl.sv
// Directed bench for set_access_ctrl: behavioural set array and next-level memory,
// expected responses queued by the stimulus and checked by a separate monitor.
module tb_set_access_ctrl;
    localparam int M_HIT = 0, M_MISS_FIRST = 1, M_MISS_ALWAYS = 2, M_NEVER = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [35:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  set_enable, set_write_enable, set_force_write;
    logic [5:0]  set_block_offset, set_idx;
    logic [23:0] set_tag;
    logic [63:0] set_write_data;
    logic [1:0]  set_data_size;
    logic [31:0] set_n_ops;
    logic [127:0] set_out_data;
    logic [1:0]  set_read_miss, set_write_miss, set_data_ready, set_op_done;
    logic        mem_req_valid, mem_req_ready;
    logic [35:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic [31:0] hit_count, miss_count;

    set_access_ctrl #(.ADDR_W(36), .TIMEOUT(64), .MAX_REPLAY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .set_enable(set_enable), .set_write_enable(set_write_enable), .set_force_write(set_force_write),
        .set_block_offset(set_block_offset), .set_idx(set_idx), .set_tag(set_tag),
        .set_write_data(set_write_data), .set_data_size(set_data_size), .set_n_ops(set_n_ops),
        .set_out_data(set_out_data), .set_read_miss(set_read_miss), .set_write_miss(set_write_miss),
        .set_data_ready(set_data_ready), .set_op_done(set_op_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    int mode = M_HIT;
    int mem_delay = 3;
    int en_cnt = 0, mem_cnt = 0;
    logic [63:0] mem_word = 64'h0;
    logic [63:0] fill_word = 64'h0;
    logic [35:0] exp_mem_addr = 36'h0;
    logic        filled = 1'b0;
    logic [1:0]  fw_size = 2'd0;
    logic [5:0]  fw_off = 6'd0;
    logic [63:0] fw_data = 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [63:0] rd, input logic err);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Monitor: one response per handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && resp_ready && !rst) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {63'h0, resp_valid}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    $display("resp rdata=%h err=%b (expected %h/%b)", resp_rdata, resp_err, e.rdata, e.err);
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {63'h0, resp_err}, {63'h0, e.err});
                end
            end
        end
    end

    // Set-array model: answers one cycle after each strobe
    initial begin
        int kind;
        set_out_data = '0; set_read_miss = 0; set_write_miss = 0; set_data_ready = 0; set_op_done = 0;
        forever begin
            @(negedge clk);
            if (set_enable != 2'd0 && !rst) begin
                en_cnt++;
                kind = 0;
                if (set_force_write != 2'd0) begin
                    fw_size = set_data_size; fw_off = set_block_offset; fw_data = set_write_data;
                    mem_word = set_write_data;
                    filled = 1'b1;
                    if (mode != M_NEVER) kind = 2;
                end else if (mode == M_NEVER) begin
                    kind = 0;
                end else if (mode == M_MISS_ALWAYS || (mode == M_MISS_FIRST && !filled)) begin
                    filled = 1'b0;
                    kind = 1;
                end else begin
                    filled = 1'b0;
                    if (set_write_enable == 2'd1) begin
                        mem_word = set_write_data;
                        kind = 2;
                    end else begin
                        kind = 3;
                    end
                end
                @(posedge clk); #1;
                set_out_data = {64'h0, mem_word};
                if (kind == 1 && set_write_enable == 2'd1) set_write_miss = 2'd1;
                if (kind == 1 && set_write_enable != 2'd1) set_read_miss = 2'd1;
                if (kind == 2) set_op_done = 2'd1;
                if (kind == 3) set_data_ready = 2'd1;
                @(posedge clk); #1;
                set_read_miss = 0; set_write_miss = 0; set_data_ready = 0; set_op_done = 0;
            end
        end
    end

    // Next-level memory model
    initial begin
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && !rst) begin
                mem_cnt++;
                check("mem_req_addr", {28'h0, mem_req_addr}, {28'h0, exp_mem_addr});
                repeat (mem_delay) @(posedge clk);
                #1 mem_resp_valid = 1'b1; mem_resp_data = fill_word;
                @(posedge clk);
                #1 mem_resp_valid = 1'b0;
            end
        end
    end

    task automatic req_start(input logic w, input logic [35:0] a, input logic [1:0] sz, input logic [63:0] wd);
        int i = 0;
        req_write = w; req_addr = a; req_size = sz; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && i < 50) begin @(negedge clk); i++; end
        if (!req_ready) check("accept_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        $display("req write=%b addr=%h size=%0d wdata=%h", w, a, sz, wd);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
        if (!resp_valid) check("resp_timeout", 64'h0, 64'h1);
    endtask

    task automatic wait_done();
        int i = 0;
        while (sb.size() != 0 && i < 300) begin @(negedge clk); i++; end
        if (sb.size() != 0) begin
            check("resp_missing", 64'(sb.size()), 64'h0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_counters(input string tag, input int ops, input int hits, input int misses);
        check({tag, "_n_ops"}, 64'(set_n_ops), 64'(ops));
        check({tag, "_hits"}, 64'(hit_count), 64'(hits));
        check({tag, "_misses"}, 64'(miss_count), 64'(misses));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en0, m0, seen;
        rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_size = 0; req_wdata = 0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        check("rst_set_enable", {62'h0, set_enable}, 64'h0);
        check("rst_mem_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_counters("rst", 0, 0, 0);
        @(posedge clk); #1;

        // Load hit, 64-bit
        mode = M_HIT; mem_word = 64'h1122_3344_5566_7788; en0 = en_cnt;
        expect_resp(64'h1122_3344_5566_7788, 1'b0);
        req_start(1'b0, {24'd1, 6'd0, 6'd8}, 2'd3, 64'h0);
        wait_resp(lat);
        check("load_hit_latency", 64'(lat), 64'd3);
        wait_done();
        check("load_hit_strobes", 64'(en_cnt - en0), 64'd1);
        check_counters("load_hit", 1, 1, 0);

        // Store byte, then load it back (upper bytes must be masked off)
        expect_resp(64'h0, 1'b0);
        req_start(1'b1, {24'd1, 6'd0, 6'd5}, 2'd0, 64'h1234_5678_9ABC_DEAB);
        wait_resp(lat);
        wait_done();
        check_counters("store", 2, 2, 0);
        expect_resp(64'h0000_0000_0000_00AB, 1'b0);
        req_start(1'b0, {24'd1, 6'd0, 6'd5}, 2'd0, 64'h0);
        wait_resp(lat);
        wait_done();
        check_counters("store_load", 3, 3, 0);

        // Read miss, fill, replay hit
        mode = M_MISS_FIRST; fill_word = 64'hDEAD_BEEF_0000_0000; mem_delay = 3;
        exp_mem_addr = {24'd2, 6'd5, 6'h18}; en0 = en_cnt; m0 = mem_cnt;
        expect_resp(64'hDEAD_BEEF_0000_0000, 1'b0);
        req_start(1'b0, {24'd2, 6'd5, 6'h18}, 2'd3, 64'h0);
        wait_resp(lat);
        wait_done();
        check("miss_fill_size", {62'h0, fw_size}, 64'd3);
        check("miss_fill_offset", {58'h0, fw_off}, 64'h18);
        check("miss_fill_data", fw_data, 64'hDEAD_BEEF_0000_0000);
        check("miss_strobes", 64'(en_cnt - en0), 64'd3);
        check("miss_mem_reqs", 64'(mem_cnt - m0), 64'd1);
        check_counters("miss", 4, 4, 1);

        // Misaligned 32-bit access
        en0 = en_cnt;
        expect_resp(64'h0, 1'b1);
        req_start(1'b0, {24'd3, 6'd1, 6'd6}, 2'd2, 64'h0);
        wait_resp(lat);
        check("misaligned_latency_le2", 64'(lat <= 2), 64'h1);
        wait_done();
        check("misaligned_strobes", 64'(en_cnt - en0), 64'd0);
        check_counters("misaligned", 5, 4, 1);

        // Array silent -> timeout; response held while resp_ready low
        mode = M_NEVER; resp_ready = 1'b0;
        expect_resp(64'h0, 1'b1);
        req_start(1'b0, {24'd4, 6'd2, 6'd0}, 2'd3, 64'h0);
        wait_resp(lat);
        check("timeout_latency", 64'(lat), 64'd66);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("resp_hold_5_cycles", 64'(seen), 64'd5);
        @(posedge clk); #1 resp_ready = 1'b1;
        wait_done();
        check_counters("timeout", 6, 4, 1);

        // Miss again on replay -> exhausted
        mode = M_MISS_ALWAYS; fill_word = 64'h5555_AAAA_5555_AAAA;
        exp_mem_addr = {24'd3, 6'd7, 6'h10}; m0 = mem_cnt;
        expect_resp(64'h0, 1'b1);
        req_start(1'b0, {24'd3, 6'd7, 6'h14}, 2'd2, 64'h0);
        wait_resp(lat);
        wait_done();
        check("exhaust_mem_reqs", 64'(mem_cnt - m0), 64'd1);
        check_counters("exhaust", 7, 4, 2);

        // Reset while waiting for fill; late fill data must be ignored
        mode = M_MISS_FIRST; mem_delay = 6; m0 = mem_cnt;
        exp_mem_addr = {24'd5, 6'd3, 6'h08};
        req_start(1'b0, {24'd5, 6'd3, 6'h08}, 2'd3, 64'h0);
        seen = 0;
        while (mem_cnt == m0 && seen < 50) begin @(negedge clk); seen++; end
        check("rst_test_mem_req_seen", 64'(mem_cnt - m0), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst_mid_no_resp", 64'(seen), 64'd0);
        check("rst_mid_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_mid_set_enable", {62'h0, set_enable}, 64'h0);
        check_counters("rst_mid", 0, 0, 0);
        @(posedge clk); #1;

        // Recovery load after reset
        mode = M_HIT; mem_word = 64'h0000_0000_0000_BEEF; mem_delay = 3;
        expect_resp(64'h0000_0000_0000_BEEF, 1'b0);
        req_start(1'b0, {24'd6, 6'd4, 6'd2}, 2'd1, 64'h0);
        wait_resp(lat);
        wait_done();
        check_counters("recover", 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
